// File: rtl/mul_final_stage.sv
// mul_final_stage: last two pipeline registers of the 32x32 Booth/Wallace
// multiplier. It resolves the Wallace sum/carry pair into a 64-bit product,
// selects the low or high word, and hands it to EXE/MEM over a valid/ready
// handshake with backpressure and flush.
//
// Optional build macro: MUL_SPLIT_ADD_EN
//   defined   - the low 32 bits of the add (and their carry-out) are done in
//               s1, and s2 finishes the upper 32 bits. This shortens the s2 add.
//   undefined - s1 holds raw S and shifted C, and s2 does the whole 64-bit add.
// Latency, handshake and results are identical in both builds.
module mul_final_stage #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_s,
    input  logic [63:0]      in_c,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int STAGES = 2;

    // Operation encodings. MULH_W and MULH_WU differ only upstream, where
    // signedness was already folded into the partial products.
    localparam logic [1:0] OP_MUL_W   = 2'b00;
    localparam logic [1:0] OP_MULH_W  = 2'b01;
    localparam logic [1:0] OP_MULH_WU = 2'b10;

`ifdef MUL_SPLIT_ADD_EN
    // s1 payload: finished low word plus its carry, and the raw upper halves.
    typedef struct packed {
        logic [31:0]      lo;
        logic             cy;
        logic [31:0]      s_hi;
        logic [31:0]      c_hi;
        logic [1:0]       op;
        logic [TAG_W-1:0] tag;
    } s1_t;
`else
    // s1 payload: raw sum vector and the carry vector already aligned by one.
    typedef struct packed {
        logic [63:0]      s;
        logic [63:0]      c;
        logic [1:0]       op;
        logic [TAG_W-1:0] tag;
    } s1_t;
`endif

    // s2 payload: completed product with its op and tag.
    typedef struct packed {
        logic [63:0]      prod;
        logic [1:0]       op;
        logic [TAG_W-1:0] tag;
    } s2_t;

    // vld_pipe[1] = s1 occupied, vld_pipe[2] = s2 occupied.
    logic [STAGES:1] vld_pipe;
    s1_t             s1_d, s1_q;
    s2_t             s2_d, s2_q;
    logic            s2_free;
    logic            s1_adv;
    logic            in_fire;
    logic            hi_sel;

    // C bit 63 has weight 2^64, which falls off the 64-bit product.
    logic            unused_c_msb;
    assign unused_c_msb = in_c[63];

    // Handshake. in_ready looks only at state, out_ready and flush, never at
    // in_valid, so the producer sees no combinational loop through us.
    assign s2_free  = !vld_pipe[2] || out_ready;
    assign s1_adv   = vld_pipe[1] && s2_free;
    assign in_ready = !flush && (!vld_pipe[1] || s2_free);
    assign in_fire  = in_valid && in_ready;

    // Build the s1 payload from the compressor outputs.
    always_comb begin
        s1_d = '0;
`ifdef MUL_SPLIT_ADD_EN
        {s1_d.cy, s1_d.lo} = {1'b0, in_s[31:0]} + {1'b0, in_c[30:0], 1'b0};
        s1_d.s_hi          = in_s[63:32];
        s1_d.c_hi          = in_c[62:31];
`else
        s1_d.s             = in_s;
        s1_d.c             = {in_c[62:0], 1'b0};
`endif
        s1_d.op            = in_op;
        s1_d.tag           = in_tag;
    end

    // Finish the product from the s1 payload. There is no carry-in: all Booth
    // correction carries were absorbed by the compressor tree.
    always_comb begin
        s2_d = '0;
`ifdef MUL_SPLIT_ADD_EN
        s2_d.prod = {s1_q.s_hi + s1_q.c_hi + {31'b0, s1_q.cy}, s1_q.lo};
`else
        s2_d.prod = s1_q.s + s1_q.c;
`endif
        s2_d.op   = s1_q.op;
        s2_d.tag  = s1_q.tag;
    end

    // Occupancy bits. A flush empties both stages but leaves the data alone.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_pipe <= '0;
        end else if (flush) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= in_fire || (vld_pipe[1] && !s2_free);
            vld_pipe[2] <= s1_adv  || (vld_pipe[2] && !out_ready);
        end
    end

    // s1 data register, loaded on every accepted input.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_q <= '0;
        end else if (in_fire) begin
            s1_q <= s1_d;
        end
    end

    // s2 data register, loaded whenever s1 hands its entry over.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s2_q <= '0;
        end else if (s1_adv) begin
            s2_q <= s2_d;
        end
    end

    // Word select straight off the s2 register, so outputs hold during a stall.
    always_comb begin
        hi_sel     = (s2_q.op == OP_MULH_W) || (s2_q.op == OP_MULH_WU);
        out_result = hi_sel ? s2_q.prod[63:32] : s2_q.prod[31:0];
    end

    assign out_valid = vld_pipe[2];
    assign out_tag   = s2_q.tag;

    // MUL_W and the reserved encoding both take the low word.
    logic unused_op_mul_w;
    assign unused_op_mul_w = ^OP_MUL_W;

endmodule

// File: tb/tb_mul_final_stage.sv
// Bench for mul_final_stage: directed cases for carries, throughput,
// backpressure, flush and reset, followed by randomized traffic. Each accepted
// input pushes its expected result; a negedge monitor pops on every output
// handshake.
module tb_mul_final_stage;

    localparam int TAG_W = 5;

    logic             clk;
    logic             resetn;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_s;
    logic [63:0]      in_c;
    logic [1:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;

    mul_final_stage #(.TAG_W(TAG_W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_s       (in_s),
        .in_c       (in_c),
        .in_op      (in_op),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: the product is S + 2*C modulo 2^64, and the high-word ops
    // return bits 63:32.
    function automatic logic [31:0] ref_res(input logic [63:0] s, input logic [63:0] c,
                                            input logic [1:0] op);
        logic [63:0] p;
        p = s + (c << 1);
        return (op == 2'd1 || op == 2'd2) ? p[63:32] : p[31:0];
    endfunction

    // Monitor / scoreboard.
    logic             prev_stall = 1'b0;
    logic [31:0]      prev_res;
    logic [TAG_W-1:0] prev_tag;
    always @(negedge clk) begin
        if (!resetn) begin
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && out_valid) begin
                check("stall_hold_result", 64'(out_result), 64'(prev_res));
                check("stall_hold_tag", 64'(out_tag), 64'(prev_tag));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: got result %0h tag %0h, expected none",
                             out_result, out_tag);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result", 64'(out_result), 64'(e.res));
                    check("tag", 64'(out_tag), 64'(e.tag));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = out_result;
            prev_tag   = out_tag;
            if (flush) begin
                sb.delete();
            end else if (in_valid && in_ready) begin
                exp_t e;
                e.res = ref_res(in_s, in_c, in_op);
                e.tag = in_tag;
                sb.push_back(e);
            end
        end
    end

    // Present one input from posedge+1 and return at posedge+1 after the edge
    // that accepted it. waits = cycles spent with in_ready low.
    task automatic send(input logic [63:0] s, input logic [63:0] c, input logic [1:0] op,
                        input logic [TAG_W-1:0] tag, output int waits);
        logic acc;
        in_s     = s;
        in_c     = c;
        in_op    = op;
        in_tag   = tag;
        in_valid = 1'b1;
        waits    = 0;
        acc      = 1'b0;
        while (!acc && waits < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (!acc) waits++;
        end
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: got no acceptance, expected acceptance within 100 cycles");
        end
        in_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        int k;
        logic [63:0] rs;
        logic [63:0] rc;

        resetn    = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_s      = '0;
        in_c      = '0;
        in_op     = '0;
        in_tag    = '0;
        out_ready = 1'b1;

        // Reset state.
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", 64'(out_result), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        tick();
        resetn = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        tick();

        // Carry crossing the word boundary, plus two-edge latency.
        send(64'h0000_0000_FFFF_FFFF, 64'h1, 2'b00, 5'd3, w);
        check("cross_accept_wait", 64'(w), 64'd0);
        check("lat_after_edge_n", 64'(out_valid), 64'd0);
        tick();
        check("lat_after_edge_n1", 64'(out_valid), 64'd1);
        check("cross_lo_direct", 64'(out_result), 64'h1);
        send(64'h0000_0000_FFFF_FFFF, 64'h1, 2'b01, 5'd4, w);
        tick();
        check("cross_hi_direct", 64'(out_result), 64'h1);

        // Wraparound with C[63] discarded.
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 2'b10, 5'd5, w);
        tick();
        check("wrap_direct", 64'(out_result), 64'h0);
        tick();

        // Back-to-back at full rate.
        for (int i = 1; i <= 4; i++) begin
            send(64'(i * 16), 64'h0, 2'b00, TAG_W'(i), w);
            check("b2b_no_wait", 64'(w), 64'd0);
        end
        check("b2b_tag3", 64'(out_tag), 64'd3);
        tick();
        check("b2b_tag4", 64'(out_tag), 64'd4);
        check("b2b_res4", 64'(out_result), 64'h40);
        tick();
        check("b2b_drained", 64'(out_valid), 64'd0);

        // Backpressure: two entries fit, then in_ready drops.
        out_ready = 1'b0;
        send(64'h1234_5678_9ABC_DEF0, 64'h0000_0001_0000_0003, 2'b00, 5'd10, w);
        check("bp_accept_a", 64'(w), 64'd0);
        send(64'h0000_0000_0000_0100, 64'h0000_0000_0000_0002, 2'b00, 5'd11, w);
        check("bp_accept_b", 64'(w), 64'd0);
        in_valid = 1'b1;
        in_s     = 64'h77;
        in_c     = 64'h0;
        in_op    = 2'b00;
        in_tag   = 5'd12;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready_low", 64'(in_ready), 64'd0);
            check("bp_hold_first", 64'(out_result),
                  64'(ref_res(64'h1234_5678_9ABC_DEF0, 64'h0000_0001_0000_0003, 2'b00)));
            tick();
        end
        out_ready = 1'b1;
        send(64'h77, 64'h0, 2'b00, 5'd12, w);
        repeat (3) tick();

        // Flush with an input presented in the same cycle.
        send(64'hAAAA, 64'h1, 2'b00, 5'd20, w);
        send(64'hBBBB, 64'h1, 2'b00, 5'd21, w);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_s     = 64'hDEAD;
        in_tag   = 5'd22;
        @(negedge clk);
        check("flush_in_ready", 64'(in_ready), 64'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        send(64'hCAFE, 64'h2, 2'b00, 5'd23, w);
        check("post_flush_n", 64'(out_valid), 64'd0);
        tick();
        check("post_flush_n1", 64'(out_valid), 64'd1);
        check("post_flush_tag", 64'(out_tag), 64'd23);
        tick();

        // Randomized traffic with stalls and occasional flushes.
        for (int i = 0; i < 600; i++) begin
            rs = {$urandom, $urandom};
            rc = {$urandom, $urandom};
            if ($urandom_range(3) == 0) rs[31:0] = 32'hFFFF_FFFF;
            in_valid  = ($urandom_range(3) != 0);
            in_s      = rs;
            in_c      = rc;
            in_op     = 2'($urandom_range(3));
            in_tag    = TAG_W'($urandom);
            out_ready = ($urandom_range(3) != 0);
            flush     = ($urandom_range(24) == 0);
            tick();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();

        // Asynchronous reset with both stages full.
        out_ready = 1'b0;
        send(64'h1111_2222_3333_4444, 64'h5, 2'b01, 5'd30, w);
        send(64'h5555_6666_7777_8888, 64'h6, 2'b00, 5'd31, w);
        check("pre_rst_full", 64'(out_valid), 64'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_result", 64'(out_result), 64'd0);
        check("async_rst_tag", 64'(out_tag), 64'd0);
        tick();
        tick();
        resetn    = 1'b1;
        out_ready = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_no_pulse", 64'(out_valid), 64'd0);
        end

        // Drain check.
        k = 0;
        while (sb.size() != 0 && k < 50) begin
            tick();
            k++;
        end
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
